// File: rtl/bmp_binarize_core_pkg.sv
// Shared constants, state encoding and gray-weight helper for the BMP binarizer.
// Imported by the core and its RAM.
package bmp_binarize_core_pkg;

   localparam int BYTE_WIDTH = 8;
   localparam int HDR_LEN    = 54;
   localparam int GRAY_SHIFT = 8;

   localparam logic [7:0] W_B = 8'd29;
   localparam logic [7:0] W_G = 8'd150;
   localparam logic [7:0] W_R = 8'd77;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_GRAY       = 3'd1,
      ST_GRAY_FLUSH = 3'd2,
      ST_BIN        = 3'd3,
      ST_BIN_FLUSH  = 3'd4,
      ST_DONE       = 3'd5
   } state_t;

   // Weights sum to 256, so the full 16-bit sum never overflows.
   function automatic logic [15:0] weigh(input logic [7:0] px, input logic [7:0] w);
      return {8'd0, px} * {8'd0, w};
   endfunction

endpackage

// File: rtl/bmp_binarize_core_if.sv
// Start/ROM/status/readback bundle of the BMP binarizer.
// master is the core side, slave is the ROM and host side.
interface bmp_binarize_core_if #(
   parameter int ADDR_WIDTH = 20
) ();

   logic                  in_valid;
   logic                  ROM_valid;
   logic [ADDR_WIDTH-1:0] ROM_addr;
   logic [7:0]            ROM_Q;
   logic                  gray_done;
   logic                  done;
   logic [ADDR_WIDTH-1:0] dump_addr;
   logic [7:0]            dump_q;

   modport master (
      input  in_valid,
      input  ROM_Q,
      input  dump_addr,
      output ROM_valid,
      output ROM_addr,
      output gray_done,
      output done,
      output dump_q
   );

   modport slave (
      output in_valid,
      output ROM_Q,
      output dump_addr,
      input  ROM_valid,
      input  ROM_addr,
      input  gray_done,
      input  done,
      input  dump_q
   );

endinterface

// File: rtl/bmp_dual_port_ram.sv
// Dual-port byte RAM: synchronous read-first ports, port 1 wins on write collision.
// Contents are never cleared; only the read registers reset.
module bmp_dual_port_ram
   import bmp_binarize_core_pkg::*;
#(
   parameter int ADDR_WIDTH = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  re1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [BYTE_WIDTH-1:0] wdata1,
   output logic [BYTE_WIDTH-1:0] q1,
   input  logic                  re2,
   input  logic                  we2,
   input  logic [ADDR_WIDTH-1:0] addr2,
   input  logic [BYTE_WIDTH-1:0] wdata2,
   output logic [BYTE_WIDTH-1:0] q2
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [BYTE_WIDTH-1:0] mem [DEPTH];

   // Array write; port 1 is applied last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (we2) begin
         mem[addr2] <= wdata2;
      end
      if (we1) begin
         mem[addr1] <= wdata1;
      end
   end

   // Read registers; non-blocking writes above make same-address reads return old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1 <= 8'h00;
         q2 <= 8'h00;
      end else begin
         if (re1) begin
            q1 <= mem[addr1];
         end
         if (re2) begin
            q2 <= mem[addr2];
         end
      end
   end

endmodule

// File: rtl/bmp_binarize_core.sv
// Two-pass BMP converter: ROM BGR -> gray into RAM, then in-place threshold to 0x00/0xFF.
// The header bytes are copied through unchanged.
module bmp_binarize_core
   import bmp_binarize_core_pkg::*;
#(
   parameter int IMG_W      = 512,
   parameter int IMG_H      = 512,
   parameter int HDR_BYTES  = HDR_LEN,
   parameter int ADDR_WIDTH = 20,
   parameter int THRESH     = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   bmp_binarize_core_if.master bus
);

   localparam int TOTAL = HDR_BYTES + 3 * IMG_W * IMG_H;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
   localparam logic [ADDR_WIDTH-1:0] HDR_ADDR  = ADDR_WIDTH'(HDR_BYTES);
   localparam logic [7:0]            THRESH_B  = 8'(THRESH);

   state_t                state_r;
   logic                  rom_valid_r;
   logic [ADDR_WIDTH-1:0] rom_addr_r;
   logic                  rsp_valid_r;
   logic [ADDR_WIDTH-1:0] rsp_addr_r;
   logic [1:0]            pix_phase_r;
   logic [15:0]           acc_r;
   logic                  p1_we_r;
   logic [ADDR_WIDTH-1:0] p1_addr_r;
   logic [7:0]            p1_data_r;
   logic [1:0]            pend_r;
   logic                  p2_re_r;
   logic [ADDR_WIDTH-1:0] p2_addr_r;
   logic                  bin_valid_r;
   logic [ADDR_WIDTH-1:0] bin_addr_r;
   logic                  gray_done_r;
   logic                  done_r;

   logic                  p2_re_s;
   logic [ADDR_WIDTH-1:0] p2_addr_s;
   logic [7:0]            p2_q_s;
   logic [7:0]            p1_q_unused;
   logic [15:0]           gray_sum_s;
   logic [7:0]            gray_s;
   logic [7:0]            bin_byte_s;

   assign gray_sum_s = acc_r + weigh(bus.ROM_Q, W_R);
   assign gray_s     = 8'(gray_sum_s >> GRAY_SHIFT);
   assign bin_byte_s = (p2_q_s >= THRESH_B) ? 8'hFF : 8'h00;

   // Port 2 serves the binarize reads, then the host readback once finished.
   always_comb begin
      p2_re_s   = p2_re_r;
      p2_addr_s = p2_addr_r;
      if (state_r == ST_DONE) begin
         p2_re_s   = 1'b1;
         p2_addr_s = bus.dump_addr;
      end else begin
         p2_re_s   = p2_re_r;
         p2_addr_s = p2_addr_r;
      end
   end

   // Main sequencer: ROM fetch, gray accumulate/write-back, binarize read-modify-write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         rom_valid_r <= 1'b0;
         rom_addr_r  <= '0;
         rsp_valid_r <= 1'b0;
         rsp_addr_r  <= '0;
         pix_phase_r <= 2'd0;
         acc_r       <= 16'd0;
         p1_we_r     <= 1'b0;
         p1_addr_r   <= '0;
         p1_data_r   <= 8'h00;
         pend_r      <= 2'd0;
         p2_re_r     <= 1'b0;
         p2_addr_r   <= '0;
         bin_valid_r <= 1'b0;
         bin_addr_r  <= '0;
         gray_done_r <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         rsp_valid_r <= rom_valid_r;
         rsp_addr_r  <= rom_addr_r;
         bin_valid_r <= p2_re_r;
         bin_addr_r  <= p2_addr_r;
         p1_we_r     <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  state_r     <= ST_GRAY;
                  rom_valid_r <= 1'b1;
                  rom_addr_r  <= '0;
                  pix_phase_r <= 2'd0;
                  acc_r       <= 16'd0;
                  pend_r      <= 2'd0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_GRAY: begin
               if (rom_valid_r) begin
                  if (rom_addr_r == LAST_ADDR) begin
                     rom_valid_r <= 1'b0;
                  end else begin
                     rom_addr_r <= rom_addr_r + ADDR_WIDTH'(1);
                  end
               end
               if (rsp_valid_r && (rsp_addr_r >= HDR_ADDR)) begin
                  case (pix_phase_r)
                     2'd0: begin
                        acc_r       <= weigh(bus.ROM_Q, W_B);
                        pix_phase_r <= 2'd1;
                     end
                     2'd1: begin
                        acc_r       <= acc_r + weigh(bus.ROM_Q, W_G);
                        pix_phase_r <= 2'd2;
                     end
                     default: begin
                        pix_phase_r <= 2'd0;
                     end
                  endcase
               end
               // A finished pixel owns port 1 for three cycles while the next one is fetched.
               if (rsp_valid_r && (rsp_addr_r >= HDR_ADDR) && (pix_phase_r == 2'd2)) begin
                  p1_we_r   <= 1'b1;
                  p1_addr_r <= rsp_addr_r - ADDR_WIDTH'(2);
                  p1_data_r <= gray_s;
                  pend_r    <= 2'd2;
               end else if (pend_r != 2'd0) begin
                  p1_we_r   <= 1'b1;
                  p1_addr_r <= p1_addr_r + ADDR_WIDTH'(1);
                  pend_r    <= pend_r - 2'd1;
               end else if (rsp_valid_r) begin
                  p1_we_r   <= 1'b1;
                  p1_addr_r <= rsp_addr_r;
                  p1_data_r <= bus.ROM_Q;
               end
               if (rsp_valid_r && (rsp_addr_r == LAST_ADDR)) begin
                  state_r <= ST_GRAY_FLUSH;
               end
            end
            ST_GRAY_FLUSH: begin
               if (pend_r != 2'd0) begin
                  p1_we_r   <= 1'b1;
                  p1_addr_r <= p1_addr_r + ADDR_WIDTH'(1);
                  pend_r    <= pend_r - 2'd1;
               end else begin
                  gray_done_r <= 1'b1;
                  state_r     <= ST_BIN;
                  p2_re_r     <= 1'b1;
                  p2_addr_r   <= HDR_ADDR;
               end
            end
            ST_BIN: begin
               if (p2_re_r) begin
                  if (p2_addr_r == LAST_ADDR) begin
                     p2_re_r <= 1'b0;
                  end else begin
                     p2_addr_r <= p2_addr_r + ADDR_WIDTH'(1);
                  end
               end
               if (bin_valid_r) begin
                  p1_we_r   <= 1'b1;
                  p1_addr_r <= bin_addr_r;
                  p1_data_r <= bin_byte_s;
                  if (bin_addr_r == LAST_ADDR) begin
                     state_r <= ST_BIN_FLUSH;
                  end
               end
            end
            ST_BIN_FLUSH: begin
               done_r  <= 1'b1;
               state_r <= ST_DONE;
            end
            ST_DONE: begin
               state_r <= ST_DONE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   bmp_dual_port_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk    (clk),
      .rst_n  (rst_n),
      .re1    (1'b0),
      .we1    (p1_we_r),
      .addr1  (p1_addr_r),
      .wdata1 (p1_data_r),
      .q1     (p1_q_unused),
      .re2    (p2_re_s),
      .we2    (1'b0),
      .addr2  (p2_addr_s),
      .wdata2 (8'h00),
      .q2     (p2_q_s)
   );

   assign bus.ROM_valid = rom_valid_r;
   assign bus.ROM_addr  = rom_addr_r;
   assign bus.gray_done = gray_done_r;
   assign bus.done      = done_r;
   assign bus.dump_q    = p2_q_s;

endmodule

// File: tb/tb_bmp_binarize_core.sv
// Directed bench for bmp_binarize_core on a 4x2 image with a one-cycle-latency ROM model.
module tb_bmp_binarize_core;

   localparam int W     = 4;
   localparam int H     = 2;
   localparam int HDR   = 54;
   localparam int AW    = 7;
   localparam int TOTAL = HDR + 3 * W * H;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [7:0] rom [0:127];
   logic [7:0] pb [8];
   logic [7:0] pg [8];
   logic [7:0] pr [8];
   logic [7:0] ex [8];

   bmp_binarize_core_if #(.ADDR_WIDTH(AW)) bus ();

   bmp_binarize_core #(
      .IMG_W      (W),
      .IMG_H      (H),
      .HDR_BYTES  (HDR),
      .ADDR_WIDTH (AW),
      .THRESH     (128)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: data one cycle after an enabled address.
   always @(posedge clk) begin
      if (bus.ROM_valid) begin
         bus.ROM_Q <= rom[bus.ROM_addr];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rv_cnt;
      int rv_runs;
      int addr_err;
      int g_k;
      int d_k;
      int rv_late;
      int drops;
      int idle_hits;
      logic prev_rv;
      logic [7:0] exp_b;

      total = 0;
      bad   = 0;
      for (int i = 0; i < 128; i++) rom[i] = 8'(i);
      rom[0] = 8'h42;
      rom[1] = 8'h4D;
      // BGR per pixel and the expected binarized byte (gray computed by hand).
      pb[0] = 8'hFF; pg[0] = 8'hFF; pr[0] = 8'hFF; ex[0] = 8'hFF; // 255
      pb[1] = 8'h00; pg[1] = 8'h00; pr[1] = 8'h00; ex[1] = 8'h00; // 0
      pb[2] = 8'h00; pg[2] = 8'd218; pr[2] = 8'h00; ex[2] = 8'h00; // 127
      pb[3] = 8'h00; pg[3] = 8'd219; pr[3] = 8'h00; ex[3] = 8'hFF; // 128
      pb[4] = 8'h00; pg[4] = 8'h00; pr[4] = 8'hFF; ex[4] = 8'h00; // 76
      pb[5] = 8'hFF; pg[5] = 8'h00; pr[5] = 8'h00; ex[5] = 8'h00; // 28
      pb[6] = 8'h80; pg[6] = 8'h80; pr[6] = 8'h80; ex[6] = 8'hFF; // 128
      pb[7] = 8'd10; pg[7] = 8'd200; pr[7] = 8'd100; ex[7] = 8'hFF; // 148
      for (int p = 0; p < 8; p++) begin
         rom[HDR + 3 * p]     = pb[p];
         rom[HDR + 3 * p + 1] = pg[p];
         rom[HDR + 3 * p + 2] = pr[p];
      end

      bus.in_valid  = 1'b0;
      bus.dump_addr = '0;
      rst_n = 1'b0;
      tick();
      tick();
      check_eq("rst_rom_valid", 32'(bus.ROM_valid), 32'd0);
      check_eq("rst_rom_addr", 32'(bus.ROM_addr), 32'd0);
      check_eq("rst_gray_done", 32'(bus.gray_done), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_dump_q", 32'(bus.dump_q), 32'd0);
      rst_n = 1'b1;

      idle_hits = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (bus.ROM_valid || bus.gray_done || bus.done) idle_hits++;
      end
      check_eq("idle_quiet", 32'(idle_hits), 32'd0);

      // Abort a pass mid-GRAY.
      bus.in_valid = 1'b1;
      for (int k = 0; k < 30; k++) tick();
      check_eq("mid_rom_valid", 32'(bus.ROM_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("abort_rom_valid", 32'(bus.ROM_valid), 32'd0);
      check_eq("abort_rom_addr", 32'(bus.ROM_addr), 32'd0);
      check_eq("abort_outputs", 32'({bus.gray_done, bus.done, bus.dump_q}), 32'd0);
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Full pass with in_valid held high throughout.
      bus.in_valid = 1'b1;
      rv_cnt = 0; rv_runs = 0; addr_err = 0; g_k = 0; d_k = 0; prev_rv = 1'b0;
      for (int k = 1; k <= 400 && d_k == 0; k++) begin
         tick();
         if (bus.ROM_valid) begin
            if (bus.ROM_addr !== AW'(rv_cnt)) addr_err++;
            rv_cnt++;
            if (!prev_rv) rv_runs++;
         end
         prev_rv = bus.ROM_valid;
         if (g_k == 0 && bus.gray_done) g_k = k;
         if (d_k == 0 && bus.done) d_k = k;
      end
      check_eq("rom_valid_cycles", 32'(rv_cnt), 32'(TOTAL));
      check_eq("rom_valid_runs", 32'(rv_runs), 32'd1);
      check_eq("rom_addr_seq", 32'(addr_err), 32'd0);
      check_eq("gray_done_seen", 32'(g_k != 0), 32'd1);
      check_eq("done_seen", 32'(d_k != 0), 32'd1);
      check_eq("gray_before_done", 32'(g_k != 0 && g_k < d_k), 32'd1);
      check_eq("gray_latency", 32'(g_k >= 1 && (g_k - 1) <= TOTAL + 8), 32'd1);
      check_eq("bin_latency", 32'(d_k > g_k && (d_k - g_k) <= 3 * W * H + 8), 32'd1);

      rv_late = 0; drops = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.ROM_valid) rv_late++;
         if (!bus.gray_done || !bus.done) drops++;
      end
      check_eq("single_pass", 32'(rv_late), 32'd0);
      check_eq("status_held", 32'(drops), 32'd0);
      bus.in_valid = 1'b0;

      for (int a = 0; a < TOTAL; a++) begin
         bus.dump_addr = AW'(a);
         tick();
         if (a < HDR) exp_b = rom[a];
         else exp_b = ex[(a - HDR) / 3];
         check_eq($sformatf("dump_%0d", a), 32'(bus.dump_q), 32'(exp_b));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
